maxpool2x2: RTL and testbench



---
 rtl/maxpool2x2_if.sv | 54 +++++
 rtl/maxpool2x2.sv | 239 +++++++++++++++++++++++
 tb/tb_maxpool2x2.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool2x2_if.sv
`default_nettype none
// ============================================================================
// Module   : maxpool2x2_if
// Purpose  : Bundles the start/finish handshake and the four memory ports of
//            the 2x2 max-pooling stage.
//              start/finish          : run handshake
//              M1/M2 R_req/addr/data : word reads of the two 26x26 input maps
//              M3/M4 W_req/addr/data : byte-enabled word writes of the pooled
//                                      13x13 maps
//            modport master : pooling engine side
//            modport slave  : memories / controller side
// Revision : 1.0 - initial release
// ============================================================================
interface maxpool2x2_if;
    logic        start;
    logic        finish;

    logic        M1_R_req;
    logic [31:0] M1_addr;
    logic [31:0] M1_R_data;
    logic        M2_R_req;
    logic [31:0] M2_addr;
    logic [31:0] M2_R_data;

    logic [3:0]  M3_W_req;
    logic [31:0] M3_addr;
    logic [31:0] M3_W_data;
    logic [3:0]  M4_W_req;
    logic [31:0] M4_addr;
    logic [31:0] M4_W_data;

    modport master (
        input  start,
        output finish,
        output M1_R_req, M1_addr,
        input  M1_R_data,
        output M2_R_req, M2_addr,
        input  M2_R_data,
        output M3_W_req, M3_addr, M3_W_data,
        output M4_W_req, M4_addr, M4_W_data
    );

    modport slave (
        output start,
        input  finish,
        input  M1_R_req, M1_addr,
        output M1_R_data,
        input  M2_R_req, M2_addr,
        output M2_R_data,
        input  M3_W_req, M3_addr, M3_W_data,
        input  M4_W_req, M4_addr, M4_W_data
    );
endinterface
`default_nettype wire

// File: rtl/maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : maxpool2x2
// Purpose  : 2x2 stride-2 max pooling of two IN_DIM x IN_DIM byte maps
//            (M1, M2) into two OUT_DIM x OUT_DIM maps (M3, M4).
//            For every output row R the two input rows 2R/2R+1 (one aligned
//            run of OUT_DIM words) are fetched into a pair buffer per channel,
//            then OUT_DIM pooled bytes are produced, packed big-endian four per
//            word and written out as soon as a word is complete.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous reset, active low
//            bus  - maxpool2x2_if.master (start/finish, M1..M4 ports)
// Revision : 1.0 - initial release
// ============================================================================
module maxpool2x2 #(
    parameter int IN_DIM    = 26,
    parameter int OUT_DIM   = IN_DIM / 2,
    parameter int OUT_BYTES = OUT_DIM * OUT_DIM
) (
    input  logic         clk,
    input  logic         rst,
    maxpool2x2_if.master bus
);

    localparam int c_pair_bytes = 2 * IN_DIM;
    localparam int c_pair_words = c_pair_bytes / 4;        // equals OUT_DIM
    localparam int c_cw         = $clog2(c_pair_words + 1);
    localparam int c_rw         = $clog2(OUT_DIM);
    localparam int c_qw         = $clog2(OUT_BYTES);
    localparam int c_bw         = $clog2(c_pair_bytes);

    localparam logic [c_cw-1:0] c_last_fetch = c_cw'(c_pair_words);
    localparam logic [c_cw-1:0] c_last_pool  = c_cw'(OUT_DIM - 1);
    localparam logic [c_rw-1:0] c_last_row   = c_rw'(OUT_DIM - 1);
    localparam logic [c_qw-1:0] c_last_q     = c_qw'(OUT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_POOL  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_cw-1:0]   r_cnt;       // FETCH: read slot, POOL: window index k
    logic [c_rw-1:0]   r_row;       // output row R
    logic [c_qw-1:0]   r_q;         // linear output byte index 13R+k
    logic [7:0]        r_buf1 [c_pair_bytes];
    logic [7:0]        r_buf2 [c_pair_bytes];
    logic [31:0]       r_pack1;
    logic [31:0]       r_pack2;

    logic [3:0]        r_wr_req;
    logic [31:0]       r_wr_addr;
    logic [31:0]       r_wr_data1;
    logic [31:0]       r_wr_data2;
    logic              r_finish;

    logic              w_rd_req;
    logic [31:0]       w_rd_addr;
    logic [c_bw-1:0]   w_i0, w_i1, w_i2, w_i3;
    logic [c_bw-1:0]   w_wbase;
    logic [7:0]        w_max1, w_max2;
    logic [1:0]        w_lane;
    logic [31:0]       w_pack1, w_pack2;
    logic              w_emit;
    logic [3:0]        w_mask;

    function automatic logic [7:0] max4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        logic [7:0] m0;
        logic [7:0] m1;
        m0 = (a > b) ? a : b;
        m1 = (c > d) ? c : d;
        return (m0 > m1) ? m0 : m1;
    endfunction

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_FETCH;
            S_FETCH: if (r_cnt == c_last_fetch) w_state_nxt = S_POOL;
            S_POOL: begin
                if (r_cnt == c_last_pool) begin
                    w_state_nxt = (r_row == c_last_row) ? S_FLUSH : S_FETCH;
                end
            end
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  if (bus.start) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Read side: the last FETCH slot only collects the final word, no request.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_req  = (r_state == S_FETCH) && (r_cnt != c_last_fetch);
        w_rd_addr = '0;
        if (w_rd_req) begin
            w_rd_addr = (32'(r_row) * 32'(OUT_DIM) + 32'(r_cnt)) << 2;
        end
    end

    assign bus.M1_R_req = w_rd_req;
    assign bus.M2_R_req = w_rd_req;
    assign bus.M1_addr  = w_rd_addr;
    assign bus.M2_addr  = w_rd_addr;

    // ------------------------------------------------------------------------
    // Pooling datapath: window k covers bytes 2k,2k+1 of the upper row and
    // the same columns of the lower row (offset IN_DIM) in the pair buffer.
    // ------------------------------------------------------------------------
    always_comb begin
        w_i0    = c_bw'(r_cnt) << 1;
        w_i1    = w_i0 + c_bw'(1);
        w_i2    = w_i0 + c_bw'(IN_DIM);
        w_i3    = w_i2 + c_bw'(1);
        w_wbase = c_bw'(r_cnt - c_cw'(1)) << 2;

        w_max1  = max4(r_buf1[w_i0], r_buf1[w_i1], r_buf1[w_i2], r_buf1[w_i3]);
        w_max2  = max4(r_buf2[w_i0], r_buf2[w_i1], r_buf2[w_i2], r_buf2[w_i3]);

        w_lane  = r_q[1:0];
        w_pack1 = r_pack1;
        w_pack2 = r_pack2;
        case (w_lane)
            2'd0: begin w_pack1[31:24] = w_max1; w_pack2[31:24] = w_max2; end
            2'd1: begin w_pack1[23:16] = w_max1; w_pack2[23:16] = w_max2; end
            2'd2: begin w_pack1[15:8]  = w_max1; w_pack2[15:8]  = w_max2; end
            default: begin w_pack1[7:0] = w_max1; w_pack2[7:0] = w_max2; end
        endcase

        // A word leaves when its last lane fills or the map ends; the enable
        // mask covers lanes 0..w_lane, which is all four for a full word.
        w_emit = (w_lane == 2'd3) || (r_q == c_last_q);
        w_mask = {1'b1, (w_lane >= 2'd1), (w_lane >= 2'd2), (w_lane == 2'd3)};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_row      <= '0;
            r_q        <= '0;
            r_pack1    <= '0;
            r_pack2    <= '0;
            r_wr_req   <= '0;
            r_wr_addr  <= '0;
            r_wr_data1 <= '0;
            r_wr_data2 <= '0;
            r_finish   <= 1'b0;
            for (int i = 0; i < c_pair_bytes; i++) begin
                r_buf1[i] <= '0;
                r_buf2[i] <= '0;
            end
        end else begin
            // Write port is a single-cycle pulse.
            r_wr_req   <= '0;
            r_wr_addr  <= '0;
            r_wr_data1 <= '0;
            r_wr_data2 <= '0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_cnt    <= '0;
                        r_row    <= '0;
                        r_q      <= '0;
                        r_pack1  <= '0;
                        r_pack2  <= '0;
                        r_finish <= 1'b0;
                    end else if (r_state == S_DONE) begin
                        r_finish <= 1'b1;
                    end
                end

                S_FETCH: begin
                    // Data returns one cycle after its request.
                    if (r_cnt != '0) begin
                        for (int b = 0; b < 4; b++) begin
                            r_buf1[w_wbase + c_bw'(b)] <= bus.M1_R_data[31-8*b -: 8];
                            r_buf2[w_wbase + c_bw'(b)] <= bus.M2_R_data[31-8*b -: 8];
                        end
                    end
                    r_cnt <= (r_cnt == c_last_fetch) ? '0 : r_cnt + c_cw'(1);
                end

                S_POOL: begin
                    if (w_emit) begin
                        r_wr_req   <= w_mask;
                        r_wr_addr  <= 32'({r_q[c_qw-1:2], 2'b00});
                        r_wr_data1 <= w_pack1;
                        r_wr_data2 <= w_pack2;
                        r_pack1    <= '0;
                        r_pack2    <= '0;
                    end else begin
                        r_pack1    <= w_pack1;
                        r_pack2    <= w_pack2;
                    end
                    r_q <= r_q + c_qw'(1);
                    if (r_cnt == c_last_pool) begin
                        r_cnt <= '0;
                        if (r_row != c_last_row) begin
                            r_row <= r_row + c_rw'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end

                default: ;
            endcase
        end
    end

    assign bus.M3_W_req  = r_wr_req;
    assign bus.M4_W_req  = r_wr_req;
    assign bus.M3_addr   = r_wr_addr;
    assign bus.M4_addr   = r_wr_addr;
    assign bus.M3_W_data = r_wr_data1;
    assign bus.M4_W_data = r_wr_data2;
    assign bus.finish    = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool2x2
// Purpose  : Directed self-checking bench for maxpool2x2: memory models for
//            M1/M2 reads, capture of M3/M4 writes, and checks of timing,
//            counts and pooled data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool2x2;

    localparam int c_in_bytes  = 676;
    localparam int c_out_bytes = 169;

    logic clk = 1'b0;
    logic rst;

    maxpool2x2_if bus_if ();

    maxpool2x2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    logic [7:0]  map1 [c_in_bytes];
    logic [7:0]  map2 [c_in_bytes];
    logic [7:0]  out1 [c_out_bytes];
    logic [7:0]  out2 [c_out_bytes];
    logic [7:0]  exp1 [c_out_bytes];
    logic [7:0]  exp2 [c_out_bytes];

    int          vectors = 0;
    int          fails   = 0;
    int          rd1, rd2, wr3, wr4;
    logic [31:0] first3_addr, first3_data, first4_data;
    logic [31:0] last3_addr, last4_addr;
    logic [3:0]  last3_req, last4_req;
    int          fin_edge;
    logic        fin_at0;

    function automatic logic [31:0] mem_word(input int ch, input logic [31:0] addr);
        int w;
        logic [31:0] d;
        w = int'(addr[31:2]);
        d = 32'h0;
        if (4 * w + 3 < c_in_bytes) begin
            for (int b = 0; b < 4; b++) begin
                d[31-8*b -: 8] = (ch == 1) ? map1[4*w+b] : map2[4*w+b];
            end
        end
        return d;
    endfunction

    // Synchronous read memories: data for a request is presented next cycle.
    always @(posedge clk) begin
        bus_if.M1_R_data <= bus_if.M1_R_req ? mem_word(1, bus_if.M1_addr) : 32'h0;
        bus_if.M2_R_data <= bus_if.M2_R_req ? mem_word(2, bus_if.M2_addr) : 32'h0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        rd1 = 0; rd2 = 0; wr3 = 0; wr4 = 0;
        first3_addr = 'x; first3_data = 'x; first4_data = 'x;
        last3_addr = 'x; last4_addr = 'x; last3_req = 'x; last4_req = 'x;
        for (int i = 0; i < c_out_bytes; i++) begin
            out1[i] = 8'hEE;
            out2[i] = 8'hEE;
        end
    endtask

    // Called once per cycle at the falling edge.
    task automatic record();
        int idx;
        if (bus_if.M1_R_req) rd1++;
        if (bus_if.M2_R_req) rd2++;
        if (bus_if.M3_W_req != 4'b0) begin
            if (wr3 == 0) begin
                first3_addr = bus_if.M3_addr;
                first3_data = bus_if.M3_W_data;
            end
            wr3++;
            last3_addr = bus_if.M3_addr;
            last3_req  = bus_if.M3_W_req;
            for (int b = 0; b < 4; b++) begin
                idx = int'(bus_if.M3_addr) + b;
                if (bus_if.M3_W_req[3-b] && idx < c_out_bytes) out1[idx] = bus_if.M3_W_data[31-8*b -: 8];
            end
        end
        if (bus_if.M4_W_req != 4'b0) begin
            if (wr4 == 0) first4_data = bus_if.M4_W_data;
            wr4++;
            last4_addr = bus_if.M4_addr;
            last4_req  = bus_if.M4_W_req;
            for (int b = 0; b < 4; b++) begin
                idx = int'(bus_if.M4_addr) + b;
                if (bus_if.M4_W_req[3-b] && idx < c_out_bytes) out2[idx] = bus_if.M4_W_data[31-8*b -: 8];
            end
        end
    endtask

    // start is presented for edge 0 and kept high while n < hold; fin_edge is
    // the index of the edge after which finish is first seen high (-1: timeout).
    task automatic run_to_finish(input int hold);
        clear_sb();
        fin_edge = -1;
        fin_at0  = 1'bx;
        @(negedge clk);
        bus_if.start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if (n == hold) bus_if.start = 1'b0;
            @(negedge clk);
            record();
            if (n == 0) fin_at0 = bus_if.finish;
            if (bus_if.finish) begin
                fin_edge = n;
                break;
            end
        end
        bus_if.start = 1'b0;
    endtask

    task automatic build_expected();
        int base;
        logic [7:0] m;
        for (int r = 0; r < 13; r++) begin
            for (int k = 0; k < 13; k++) begin
                base = 52 * r + 2 * k;
                m = 8'h00;
                foreach (map1[i]) if ((i == base || i == base + 1 || i == base + 26 || i == base + 27) && map1[i] > m) m = map1[i];
                exp1[13*r+k] = m;
                m = 8'h00;
                foreach (map2[i]) if ((i == base || i == base + 1 || i == base + 26 || i == base + 27) && map2[i] > m) m = map2[i];
                exp2[13*r+k] = m;
            end
        end
    endtask

    function automatic int count_bad(input int ch);
        int n;
        n = 0;
        for (int i = 0; i < c_out_bytes; i++) begin
            if (ch == 1 && out1[i] !== exp1[i]) n++;
            if (ch == 2 && out2[i] !== exp2[i]) n++;
        end
        return n;
    endfunction

    function automatic int count_not(input int ch, input int from, input logic [7:0] v);
        int n;
        n = 0;
        for (int i = from; i < c_out_bytes; i++) begin
            if (ch == 1 && out1[i] !== v) n++;
            if (ch == 2 && out2[i] !== v) n++;
        end
        return n;
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < c_in_bytes; i++) begin
            map1[i] = 8'(i % 128);
            map2[i] = 8'(i % 128);
        end
    endtask

    task automatic check_full_run(input string tag);
        check({tag, "_finish_edge"}, 64'(fin_edge), 64'd353);
        check({tag, "_reads"}, {32'(rd1), 32'(rd2)}, {32'd169, 32'd169});
        check({tag, "_writes"}, {32'(wr3), 32'(wr4)}, {32'd43, 32'd43});
        check({tag, "_last_wr"}, {last3_addr, last4_addr, 24'h0, last3_req, last4_req},
              {32'd168, 32'd168, 24'h0, 4'b1000, 4'b1000});
    endtask

    logic [7:0] quad_vals [4];
    int         quad_pos  [4];

    initial begin
        rst          = 1'b0;
        bus_if.start = 1'b0;
        for (int i = 0; i < c_in_bytes; i++) begin
            map1[i] = 8'h00;
            map2[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("reset_ctrl", {bus_if.M1_R_req, bus_if.M2_R_req, bus_if.M3_W_req, bus_if.M4_W_req, bus_if.finish}, 64'h0);
        check("reset_addr", {bus_if.M1_addr | bus_if.M2_addr, bus_if.M3_addr | bus_if.M4_addr}, 64'h0);
        check("reset_data", {bus_if.M3_W_data, bus_if.M4_W_data}, 64'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero maps
        run_to_finish(1);
        check_full_run("zero");
        check("zero_data", {32'(count_not(1, 0, 8'h00)), 32'(count_not(2, 0, 8'h00))}, 64'h0);

        // Ramp
        fill_ramp();
        build_expected();
        run_to_finish(1);
        check_full_run("ramp");
        check("ramp_first_wr", {first3_addr, first3_data}, {32'h0, 32'h1B1D1F21});
        check("ramp_first_wr_ch2", 64'(first4_data), 64'h1B1D1F21);
        check("ramp_data", {32'(count_bad(1)), 32'(count_bad(2))}, 64'h0);

        // Single 0x55 at each position of window (0,0)
        quad_pos[0] = 0; quad_pos[1] = 1; quad_pos[2] = 26; quad_pos[3] = 27;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < c_in_bytes; i++) begin
                map1[i] = 8'h00;
                map2[i] = 8'h00;
            end
            map1[quad_pos[p]] = 8'h55;
            run_to_finish(1);
            check($sformatf("quad%0d_byte0", p), {out1[0], out2[0]}, {8'h55, 8'h00});
            check($sformatf("quad%0d_rest", p), {32'(count_not(1, 1, 8'h00)), 32'(count_not(2, 0, 8'h00))}, 64'h0);
        end

        // Unsigned compare, channels independent
        quad_vals[0] = 8'h7F; quad_vals[1] = 8'hFF; quad_vals[2] = 8'h80; quad_vals[3] = 8'h01;
        for (int i = 0; i < c_in_bytes; i++) begin
            map1[i] = 8'h00;
            map2[i] = 8'h10;
        end
        for (int p = 0; p < 4; p++) map1[quad_pos[p]] = quad_vals[p];
        run_to_finish(1);
        check("unsigned_byte0", {out1[0], out2[0]}, {8'hFF, 8'h10});
        check("unsigned_rest_ch1", 64'(count_not(1, 1, 8'h00)), 64'h0);
        check("unsigned_ch2", 64'(count_not(2, 0, 8'h10)), 64'h0);

        // Reset at edge 40 (second FETCH), then a clean restart
        fill_ramp();
        build_expected();
        clear_sb();
        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        record();
        for (int n = 1; n < 40; n++) begin
            @(negedge clk);
            record();
        end
        check("pre_reset_writes", 64'(wr3), 64'd3);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ctrl", {bus_if.M1_R_req, bus_if.M2_R_req, bus_if.M3_W_req, bus_if.M4_W_req, bus_if.finish}, 64'h0);
        check("midrst_bus", {bus_if.M1_addr | bus_if.M2_addr | bus_if.M3_addr, bus_if.M3_W_data | bus_if.M4_W_data}, 64'h0);
        clear_sb();
        repeat (2) begin
            @(negedge clk);
            record();
        end
        rst = 1'b1;
        repeat (60) begin
            @(negedge clk);
            record();
        end
        check("post_reset_quiet", {32'(wr3 + wr4), 32'(rd1 + rd2)}, 64'h0);
        run_to_finish(1);
        check_full_run("restart");
        check("restart_data", {32'(count_bad(1)), 32'(count_bad(2))}, 64'h0);

        // start held high while busy, then restart from DONE
        for (int i = 0; i < c_in_bytes; i++) map2[i] = 8'(255 - (i % 200));
        build_expected();
        run_to_finish(300);
        check_full_run("held");
        check("held_data", {32'(count_bad(1)), 32'(count_bad(2))}, 64'h0);
        run_to_finish(1);
        check("done_restart_finish_drop", 64'(fin_at0), 64'h0);
        check_full_run("done_restart");
        check("done_restart_data", {32'(count_bad(1)), 32'(count_bad(2))}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
